wraper_output: RTL and testbench
================================

// Module: wraper_output
// PURPOSE
//  Output-side wrapper placed directly downstream of the accelerator core. It arms on the
//  core's start pulse and waits for the core's ready to drop and then return high. It then
//  captures the RES_W-bit result and serialises it LSB-byte-first onto an 8-bit bus using a
//  four-phase ordy/oack handshake. obe tells the input wrapper the buffer is empty, so the
//  next calculation may start.
// PARAMETERS
//  RES_W   16   result width in bits; multiple of 8, >= 8; NB = RES_W/8 bytes per result
// PORTS
//  clk      in   1      clock, all state on rising edge
//  rst      in   1      reset, synchronous, active-low (rst==0 at a rising edge resets)
//  start    in   1      core start strobe (same net that drives the core)
//  ready    in   1      core ready: low while calculating, high when result valid
//  result   in   RES_W  core result, sampled only on capture
//  oack     in   1      consumer acknowledge (four-phase)
//  bus_out  out  8      byte presented to consumer
//  ordy     out  1      byte on bus_out is valid
//  obe      out  1      output buffer empty / wrapper idle
//  err      out  1      sticky: start seen while buffer not empty
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE, shreg=0, bcnt=0, err=0.
//   Outputs after reset: bus_out=0, ordy=0, obe=1.
//   Reset wins over every other input, including in mid-transfer.
//  States (registered, 3 bits): IDLE, ARM, CALC, SEND, HOLD.
//  IDLE: obe=1. start=1 -> ARM. oack and ready are ignored.
//  ARM: obe=1. Waits for the core to accept start.
//   ready==0 -> CALC. ready==1 -> stay in ARM.
//  CALC: obe=1. ready==1 -> capture:
//   shreg<=result, bcnt<=NB-1, state<=SEND.
//   Latency: ordy=1 in the cycle after the edge at which ready==1 is sampled in CALC.
//  SEND: obe=0, ordy=1, bus_out=shreg[7:0]. oack==1 -> HOLD. Otherwise hold everything.
//  HOLD: obe=0, ordy=0, bus_out=shreg[7:0] (held stable). Waits for oack==0.
//   oack==0 and bcnt==0 -> IDLE; shreg<=0.
//   oack==0 and bcnt!=0 -> SEND; shreg<=shreg>>8; bcnt<=bcnt-1.
//  Outputs are decoded from the state register and shreg only; no input-to-output
//   combinational path.
//  bus_out=0 in IDLE, ARM and CALC.
//  Width rules: shreg is RES_W bits and shifts with zero fill.
//   bcnt is clog2(NB) bits wide, min 1; NB==1 gives a single byte and no shift.
//  Boundaries:
//   - oack already high on entry to SEND: move to HOLD on the next edge (no stall).
//   - oack held high in HOLD: remain in HOLD indefinitely; next byte not presented.
//   - result may change at any time after capture; bus_out is unaffected.
//   - ready high in IDLE with no start: no capture.
//   - start==1 while state is not IDLE: err<=1 (sticky until reset); FSM continues unchanged.
//   - start and ready both high in IDLE: go to ARM only; capture needs the low phase.
//   - After the final byte's HOLD->IDLE edge: obe=1 from the next cycle.
// TESTING
//  1 rst=0 for 2 edges mid-anything -> bus_out=0, ordy=0, obe=1, err=0 on the next cycle.
//  2 start pulse; ready low 5 cycles then high; result=16'hA5C3
//    -> ordy=1 one cycle later, bus_out=8'hC3.
//    Four-phase oack completes -> bus_out=8'hA5, ordy=1.
//    Second oack low -> obe=1, bus_out=0.
//  3 Slow consumer: oack held high 10 cycles in HOLD -> ordy stays 0, bus_out stays 8'hC3.
//    Second byte appears only after oack returns low.
//  4 result driven to 16'hFFFF right after capture of 16'h1234 -> bytes 8'h34 then 8'h12.
//  5 rst=0 while ordy=1 on the second byte -> idle outputs next cycle; no further ordy.
//  6 start pulsed during SEND -> err=1 and stays 1.
//    Current transfer still completes (both bytes); err clears only on reset.

Source files
------------

// File: rtl/wraper_output.sv
// Output wrapper: captures the core result after its ready low/high cycle and
// serialises it LSB byte first over a four-phase ordy/oack handshake.
module wraper_output #(
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ready,
  input  logic [RES_W-1:0] result,
  input  logic             oack,
  output logic [7:0]       bus_out,
  output logic             ordy,
  output logic             obe,
  output logic             err
);

  localparam int NB = RES_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CALC,
    SEND,
    HOLD
  } state_t;

  state_t           state;
  logic [RES_W-1:0] shreg;
  logic [BW-1:0]    bcnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      bcnt  <= '0;
      err   <= 1'b0;
    end else begin
      // A new start while a result is still pending would lose data.
      if (start && state != IDLE)
        err <= 1'b1;
      case (state)
        IDLE: if (start) state <= ARM;
        ARM:  if (!ready) state <= CALC;
        CALC: begin
          if (ready) begin
            shreg <= result;
            bcnt  <= BW'(NB - 1);
            state <= SEND;
          end
        end
        SEND: if (oack) state <= HOLD;
        HOLD: begin
          if (!oack) begin
            if (bcnt == '0) begin
              state <= IDLE;
              shreg <= '0;
            end else begin
              state <= SEND;
              shreg <= shreg >> 8;
              bcnt  <= bcnt - BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ordy    = (state == SEND);
  assign obe     = (state == IDLE) || (state == ARM) ||
                   (state == CALC);
  assign bus_out = (state == SEND || state == HOLD) ?
                   shreg[7:0] : 8'h00;

endmodule

// File: tb/tb_wraper_output.sv
// Directed and randomized bench for wraper_output against a byte-queue
// reference model of the result serialisation.
module tb_wraper_output;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic [15:0] result;
  logic        oack;
  logic [7:0]  bus_out;
  logic        ordy;
  logic        obe;
  logic        err;

  int total  = 0;
  int passed = 0;
  bit err_exp = 1'b0;

  wraper_output #(.RES_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ready   (ready),
    .result  (result),
    .oack    (oack),
    .bus_out (bus_out),
    .ordy    (ordy),
    .obe     (obe),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ordy"}, 32'(ordy), 0);
    chk({tag, "_obe"}, 32'(obe), 1);
    chk({tag, "_bus"}, 32'(bus_out), 0);
  endtask

  // Model: a result becomes an ordered queue of bytes, LSB first.
  function automatic void split(input logic [15:0] r,
                                output logic [7:0] q[$]);
    q = {};
    for (int k = 0; k < 2; k++)
      q.push_back(8'((r >> (8 * k)) & 16'h00ff));
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    err_exp = 1'b0;
    chk_idle("reset");
    chk("reset_err", 32'(err), 0);
  endtask

  // Start pulse, ready low for calc_len cycles, then ready high with r.
  task automatic calc(input logic [15:0] r, input int calc_len,
                      input bit pre_ack);
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b0;
    repeat (calc_len) begin
      tick();
      chk("calc_obe", 32'(obe), 1);
      chk("calc_ordy", 32'(ordy), 0);
    end
    ready  = 1'b1;
    result = r;
    if (pre_ack) oack = 1'b1;
    tick();
  endtask

  task automatic send(input logic [15:0] r, input logic [15:0] post,
                      input int hold_extra, input bit pulse_start);
    logic [7:0] q[$];
    logic [7:0] b;
    split(r, q);
    while (q.size() > 0) begin
      b = q.pop_front();
      chk("send_ordy", 32'(ordy), 1);
      chk("send_obe", 32'(obe), 0);
      chk("send_bus", 32'(bus_out), 32'(b));
      chk("send_err", 32'(err), 32'(err_exp));
      result = post;
      if (pulse_start) begin
        start = 1'b1;
        err_exp = 1'b1;
      end
      oack = 1'b1;
      tick();
      start = 1'b0;
      pulse_start = 1'b0;
      chk("hold_ordy", 32'(ordy), 0);
      chk("hold_bus", 32'(bus_out), 32'(b));
      repeat (hold_extra) tick();
      chk("slow_ordy", 32'(ordy), 0);
      chk("slow_bus", 32'(bus_out), 32'(b));
      oack = 1'b0;
      tick();
    end
    chk_idle("done");
    chk("done_err", 32'(err), 32'(err_exp));
  endtask

  initial begin
    logic [15:0] r;
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    result = '0;
    oack = 1'b0;
    #2;
    do_reset();

    // ready and oack high in IDLE without start: nothing happens
    oack = 1'b1;
    repeat (3) tick();
    chk_idle("idle_ready");
    oack = 1'b0;

    calc(16'hA5C3, 5, 1'b0);
    send(16'hA5C3, 16'hA5C3, 0, 1'b0);

    calc(16'hA5C3, 2, 1'b0);
    send(16'hA5C3, 16'hA5C3, 10, 1'b0);

    calc(16'h1234, 3, 1'b0);
    send(16'h1234, 16'hFFFF, 1, 1'b0);

    calc(16'h00FF, 1, 1'b1);
    send(16'h00FF, 16'h5555, 0, 1'b0);

    // start during SEND sets a sticky err; transfer still completes
    calc(16'hBEEF, 2, 1'b0);
    send(16'hBEEF, 16'h0000, 0, 1'b1);
    calc(16'h0102, 1, 1'b0);
    send(16'h0102, 16'h0000, 0, 1'b0);

    // reset while the second byte is offered
    calc(16'h7E81, 2, 1'b0);
    chk("mid_b0", 32'(bus_out), 32'h81);
    oack = 1'b1;
    tick();
    oack = 1'b0;
    tick();
    chk("mid_b1", 32'(bus_out), 32'h7E);
    chk("mid_ordy", 32'(ordy), 1);
    do_reset();
    oack = 1'b1;
    tick();
    oack = 1'b0;
    repeat (2) tick();
    chk_idle("post_reset");

    // start with ready high: arms only, no capture until low phase
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("arm_ordy", 32'(ordy), 0);
    chk("arm_obe", 32'(obe), 1);
    ready = 1'b0;
    tick();
    chk("arm_calc", 32'(ordy), 0);
    ready = 1'b1;
    result = 16'hC0DE;
    tick();
    send(16'hC0DE, 16'h0000, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      r = 16'($urandom);
      calc(r, int'($urandom_range(1, 5)), 1'($urandom));
      send(r, 16'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
